// File: rtl/wb_queue.sv
// Writeback queue feeding the register-file write port: ALU results pass straight through,
// load results wait in an in-order FIFO that also answers operand lookups for queued writes.
module wb_queue #(
  parameter int DEPTH        = 4,
  parameter int AW           = 5,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [AW-1:0]              alu_wa,
  input  logic [DW-1:0]              alu_wd,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [AW-1:0]              ld_wa,
  input  logic [DW-1:0]              ld_wd,
  output logic                       we3,
  output logic [AW-1:0]              wa3,
  output logic [DW-1:0]              wd3,
  input  logic [AW-1:0]              qa1,
  input  logic [AW-1:0]              qa2,
  output logic                       qhit1,
  output logic                       qhit2,
  output logic [DW-1:0]              qdata1,
  output logic [DW-1:0]              qdata2,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(STARVE_LIMIT+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] SC_MAX  = SW'(STARVE_LIMIT);

  logic [AW-1:0] wa_mem_q [DEPTH];
  logic [DW-1:0] wd_mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] sc_q, sc_d;

  logic starve, alu_take, push, pop;

  assign starve    = (sc_q == SC_MAX);
  assign alu_ready = !reset && !starve;
  assign ld_ready  = !reset && (count_q < DEPTH_C);
  assign count     = count_q;

  assign alu_take = alu_valid && alu_ready;
  assign pop      = !reset && !alu_take && (count_q != '0);
  // Loads to r0 are acknowledged but never occupy a slot.
  assign push     = ld_valid && ld_ready && (ld_wa != '0);

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    we3 = 1'b0;
    wa3 = '0;
    wd3 = '0;
    if (alu_take) begin
      we3 = (alu_wa != '0);
      wa3 = alu_wa;
      wd3 = alu_wd;
    end else if (pop) begin
      we3 = 1'b1;
      wa3 = wa_mem_q[head_q];
      wd3 = wd_mem_q[head_q];
    end
  end

  always_comb begin
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    sc_d = sc_q;
    if (count_q == '0 || pop) sc_d = '0;
    else if (sc_q != SC_MAX)  sc_d = sc_q + SW'(1);
  end

  // Walk entries oldest to youngest so the last match wins.
  always_comb begin
    qhit1  = 1'b0;
    qhit2  = 1'b0;
    qdata1 = '0;
    qdata2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if (qa1 != '0 && wa_mem_q[head_q + PW'(i)] == qa1) begin
          qhit1  = 1'b1;
          qdata1 = wd_mem_q[head_q + PW'(i)];
        end
        if (qa2 != '0 && wa_mem_q[head_q + PW'(i)] == qa2) begin
          qhit2  = 1'b1;
          qdata2 = wd_mem_q[head_q + PW'(i)];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      sc_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      sc_q    <= sc_d;
    end
  end

  // NOTE: the storage array has no reset; validity comes only from count/head, so stale data is never seen.
  always_ff @(posedge clk) begin
    if (push) begin
      wa_mem_q[tail_q] <= ld_wa;
      wd_mem_q[tail_q] <= ld_wd;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios plus random traffic, compared each
// cycle against a queue-based reference model of the writeback rules.
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int LIMIT = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          alu_valid = 1'b0, ld_valid = 1'b0;
  logic [AW-1:0] alu_wa = '0, ld_wa = '0, qa1 = '0, qa2 = '0;
  logic [DW-1:0] alu_wd = '0, ld_wd = '0;
  logic          alu_ready, ld_ready, we3, qhit1, qhit2;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3, qdata1, qdata2;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } ent_t;

  ent_t mq[$];
  int   msc = 0;

  wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wa(ld_wa), .ld_wd(ld_wd),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .qa1(qa1), .qa2(qa2), .qhit1(qhit1), .qhit2(qhit2), .qdata1(qdata1), .qdata2(qdata2),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void lookup(input logic [AW-1:0] qa, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (qa != '0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].wa == qa) begin
          hit = 1'b1;
          d   = mq[i].wd;
          break;
        end
      end
    end
  endfunction

  // One clock cycle: compare outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    logic          starve, take, pop, push, was_empty, h;
    logic          e_we;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd, d;
    @(negedge clk);
    starve = (msc == LIMIT);
    take   = alu_valid && !starve;
    e_we = 1'b0; e_wa = '0; e_wd = '0;
    if (take) begin
      e_we = (alu_wa != '0); e_wa = alu_wa; e_wd = alu_wd;
    end else if (mq.size() != 0) begin
      e_we = 1'b1; e_wa = mq[0].wa; e_wd = mq[0].wd;
    end
    check("count",     64'(count),     64'(mq.size()));
    check("ld_ready",  64'(ld_ready),  64'(mq.size() < DEPTH));
    check("alu_ready", 64'(alu_ready), 64'(!starve));
    check("we3",       64'(we3),       64'(e_we));
    check("wa3",       64'(wa3),       64'(e_wa));
    check("wd3",       64'(wd3),       64'(e_wd));
    lookup(qa1, h, d);
    check("qhit1",  64'(qhit1),  64'(h));
    check("qdata1", 64'(qdata1), 64'(d));
    lookup(qa2, h, d);
    check("qhit2",  64'(qhit2),  64'(h));
    check("qdata2", 64'(qdata2), 64'(d));
    @(posedge clk);
    was_empty = (mq.size() == 0);
    pop  = !take && !was_empty;
    push = ld_valid && (mq.size() < DEPTH) && (ld_wa != '0);
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back('{wa: ld_wa, wd: ld_wd});
    if (was_empty || pop) msc = 0;
    else if (msc < LIMIT) msc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_count",     64'(count),     64'(0));
    check("rst_we3",       64'(we3),       64'(0));
    check("rst_ld_ready",  64'(ld_ready),  64'(0));
    check("rst_alu_ready", 64'(alu_ready), 64'(0));
    check("rst_qhit1",     64'(qhit1),     64'(0));
    check("rst_qhit2",     64'(qhit2),     64'(0));
    mq.delete();
    msc = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle();
    alu_valid = 1'b0; ld_valid = 1'b0;
    alu_wa = '0; alu_wd = '0; ld_wa = '0; ld_wd = '0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Idle after reset.
    idle();
    step();

    // ALU pass-through, then write to r0 suppressed.
    alu_valid = 1'b1; alu_wa = 5'd6; alu_wd = 32'hCA;
    step();
    alu_wa = 5'd0;
    step();

    // Single load, visible next cycle, drained that cycle.
    idle();
    ld_valid = 1'b1; ld_wa = 5'd2; ld_wd = 32'hC;
    step();
    idle();
    qa1 = 5'd2;
    #1;
    check("ld_count1", 64'(count),  64'(1));
    check("ld_qdata1", 64'(qdata1), 64'(32'hC));
    step();
    step();
    check("ld_drained", 64'(count), 64'(0));

    // Fill with ALU busy, then starvation forces the head out.
    alu_valid = 1'b1; alu_wa = 5'd9; alu_wd = 32'h99;
    qa2 = 5'd4;
    for (int k = 0; k < 4; k++) begin
      ld_valid = 1'b1; ld_wa = 5'd4; ld_wd = 32'hA + k;
      step();
    end
    ld_wd = 32'hE;
    #1;
    check("fill_count",    64'(count),    64'(4));
    check("fill_ld_ready", 64'(ld_ready), 64'(0));
    check("fill_qdata2",   64'(qdata2),   64'(32'hD));
    step();
    ld_valid = 1'b0;
    for (int k = 0; k < 20 && msc != LIMIT; k++) step();
    check("starve_reached", 64'(msc), 64'(LIMIT));
    #1;
    check("starve_alu_ready", 64'(alu_ready), 64'(0));
    check("starve_wd3",       64'(wd3),       64'(32'hA));
    step();
    check("starve_count", 64'(count), 64'(3));

    // Reset mid-run with 3 entries queued.
    do_reset();
    idle();
    step();

    // Push/pop at count 1 with the ALU idle, spanning several pointer wraps.
    ld_valid = 1'b1; ld_wa = 5'd3; ld_wd = 32'h100;
    step();
    for (int k = 0; k < 10; k++) begin
      ld_wa = 5'(1 + (k % 7)); ld_wd = 32'h200 + k;
      step();
      check("pushpop_count", 64'(count), 64'(1));
    end
    idle();
    step();
    step();

    // Random traffic with occasional reset.
    for (int n = 0; n < 2000; n++) begin
      alu_valid = ($urandom_range(0, 99) < 55);
      alu_wa    = 5'($urandom_range(0, 7));
      alu_wd    = $urandom;
      ld_valid  = ($urandom_range(0, 99) < 60);
      ld_wa     = 5'($urandom_range(0, 7));
      ld_wd     = $urandom;
      qa1       = 5'($urandom_range(0, 7));
      qa2       = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 249) == 0) do_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
